// File: rtl/msk_rnd_fifo_pkg.sv
// Shared sizing helpers for the randomness FIFO and the masked cores that consume it.
package msk_rnd_fifo_pkg;

  localparam int DEF_BUS_W  = 20;
  localparam int DEF_NBUS   = 3;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LOW_WM = 2;
  localparam int DEF_CNT_W  = 16;

  function automatic int rnd_w(input int bus_w, input int nbus);
    return bus_w * nbus;
  endfunction

  // Pointer carries one extra wrap bit above the RAM index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/msk_rnd_fifo_if.sv
// Word handshakes between the PRNG, the randomness FIFO and the masked core.
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1; ready
// and valid never depend combinationally on the opposite side's signal.
interface msk_rnd_fifo_if #(
  parameter int RND_W = 60
) ();
  logic             in_valid;
  logic             in_ready;
  logic [RND_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [RND_W-1:0] out_bus;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bus
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bus
  );
endinterface

// File: rtl/msk_rnd_fifo_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/msk_rnd_fifo.sv
// Randomness buffer between PRNG and masked cores: first-word-fall-through FIFO with
// flush, fill level, low-water flag and a sticky starvation counter.
module msk_rnd_fifo
  import msk_rnd_fifo_pkg::*;
#(
  parameter int BUS_W  = DEF_BUS_W,
  parameter int NBUS   = DEF_NBUS,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LOW_WM = DEF_LOW_WM,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int RND_W = rnd_w(BUS_W, NBUS),
  localparam int PW    = ptr_w(DEPTH),
  localparam int AW    = PW - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  msk_rnd_fifo_if.slave        io,
  output logic [PW-1:0]        level,
  output logic                 low_water,
  output logic [CNT_W-1:0]     starve_cnt
);
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d, level_q, level_d;
  logic [RND_W-1:0] mem_q [DEPTH];
  logic [RND_W-1:0] mem_d [DEPTH];
  logic             empty, full, push, pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push  = io.in_valid & ~full;
  assign pop   = io.out_ready & ~empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    mem_d   = mem_q;
    if (flush) begin
      // Discard everything; this cycle's push and pop are dropped.
      wp_d    = rp_q;
      level_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q[AW-1:0]] = io.in_data;
        wp_d                = wp_q + 1'b1;
      end
      if (pop) rp_d = rp_q + 1'b1;
      level_d = level_q + PW'(push) - PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io.in_ready  = ~full;
  assign io.out_valid = ~empty;
  assign io.out_bus   = mem_q[rp_q[AW-1:0]];
  assign level        = level_q;
  assign low_water    = (level_q <= PW'(LOW_WM));

  sat_counter #(.W(CNT_W)) u_starve (
    .clk (clk),
    .clr (rst),
    .en  (io.out_ready & empty),
    .cnt (starve_cnt)
  );
endmodule

// File: tb/tb_msk_rnd_fifo.sv
// Bench for msk_rnd_fifo: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_msk_rnd_fifo;
  localparam int BUS_W  = 20;
  localparam int NBUS   = 3;
  localparam int RND_W  = BUS_W * NBUS;
  localparam int DEPTH  = 8;
  localparam int LOW_WM = 2;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       level, level3;
  logic             low_water, low_water3;
  logic [CNT_W-1:0] starve_cnt;
  logic [2:0]       starve_cnt3;

  msk_rnd_fifo_if #(.RND_W(RND_W)) if0 ();
  msk_rnd_fifo_if #(.RND_W(RND_W)) if3 ();

  msk_rnd_fifo #(.BUS_W(BUS_W), .NBUS(NBUS), .DEPTH(DEPTH), .LOW_WM(LOW_WM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .io(if0.slave),
    .level(level), .low_water(low_water), .starve_cnt(starve_cnt)
  );

  // Narrow-counter instance, kept empty, used for the saturation check.
  assign if3.in_valid  = 1'b0;
  assign if3.in_data   = '0;
  assign if3.out_ready = if0.out_ready;
  msk_rnd_fifo #(.BUS_W(BUS_W), .NBUS(NBUS), .DEPTH(DEPTH), .LOW_WM(LOW_WM), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .io(if3.slave),
    .level(level3), .low_water(low_water3), .starve_cnt(starve_cnt3)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [RND_W-1:0] exp_q[$];
  int m_starve, m_starve3;
  int n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("level",      64'(level),       64'(exp_q.size()));
    check("out_valid",  64'(if0.out_valid), 64'(exp_q.size() > 0));
    check("in_ready",   64'(if0.in_ready),  64'(exp_q.size() < DEPTH));
    check("low_water",  64'(low_water),   64'(exp_q.size() <= LOW_WM));
    check("starve_cnt", 64'(starve_cnt),  64'(m_starve));
    check("starve3",    64'(starve_cnt3), 64'(m_starve3));
    if (exp_q.size() > 0) check("out_bus", 64'(if0.out_bus), 64'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive, check pre-edge outputs, advance model, clock.
  task automatic cycle(input bit iv, input logic [RND_W-1:0] d, input bit ordy, input bit fl);
    bit do_push, do_pop;
    if0.in_valid  = iv;
    if0.in_data   = d;
    if0.out_ready = ordy;
    flush         = fl;
    #1;
    check_all();
    if (ordy && exp_q.size() == 0 && m_starve < 65535) m_starve++;
    if (ordy && m_starve3 < 7) m_starve3++;
    if (fl) begin
      exp_q.delete();
    end else begin
      do_pop  = ordy && (exp_q.size() > 0);
      do_push = iv && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    flush         = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_data   = '0;
    if0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_starve  = 0;
    m_starve3 = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             iv;
    logic [RND_W-1:0] d;
    logic             ordy;
    logic             fl;
    int               lvl;
    logic             ov;
    logic             ir;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(bit iv, logic [RND_W-1:0] d, bit ordy, bit fl,
                                  int lvl, bit ov, bit ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.lvl = lvl; v.ov = ov; v.ir = ir;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] r64;
    bit          iv_r, ordy_r, fl_r;
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    reset_dut();
    #1;
    check("rst_in_ready",  64'(if0.in_ready),  64'd1);
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_level",     64'(level),         64'd0);
    check("rst_low_water", 64'(low_water),     64'd1);
    check("rst_starve",    64'(starve_cnt),    64'd0);

    // Fill to full, overflow attempt, drain, refill to 5, flush with push+pop, idle
    for (int i = 0; i < DEPTH; i++) add_vec(1, RND_W'(i + 1), 0, 0, i + 1, 1, (i + 1) < DEPTH);
    add_vec(1, RND_W'(9), 0, 0, DEPTH, 1, 0);
    for (int k = 0; k < DEPTH; k++) add_vec(0, '0, 1, 0, DEPTH - 1 - k, (DEPTH - 1 - k) > 0, 1);
    for (int i = 0; i < 5; i++) add_vec(1, RND_W'(8'h11 + i), 0, 0, i + 1, 1, 1);
    add_vec(1, RND_W'(16'hDEAD), 1, 1, 0, 0, 1);
    add_vec(0, '0, 0, 0, 0, 0, 1);
    foreach (vecs[n]) begin
      cycle(vecs[n].iv, vecs[n].d, vecs[n].ordy, vecs[n].fl);
      #1;
      check("tbl_level",     64'(level),         64'(vecs[n].lvl));
      check("tbl_out_valid", 64'(if0.out_valid), 64'(vecs[n].ov));
      check("tbl_in_ready",  64'(if0.in_ready),  64'(vecs[n].ir));
    end

    // Steady stream across several pointer wraps
    for (int i = 0; i < 100; i++) cycle(1, RND_W'(32'h1000 + i), 1, 0);
    #1;
    check("stream_level", 64'(level), 64'd1);
    check("stream_head",  64'(if0.out_bus), 64'(32'h1000 + 99));

    // Starvation count, saturation, flush keeps it, reset clears it
    reset_dut();
    for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0);
    check("starve_10", 64'(starve_cnt), 64'd10);
    for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0);
    check("starve_20",   64'(starve_cnt),  64'd20);
    check("starve3_sat", 64'(starve_cnt3), 64'd7);
    cycle(0, '0, 0, 1);
    check("starve_flush_kept", 64'(starve_cnt), 64'd20);
    reset_dut();
    #1;
    check("starve_rst_clr", 64'(starve_cnt), 64'd0);

    // Reset mid-stream with level 4
    for (int i = 0; i < 4; i++) cycle(1, RND_W'(32'h500 + i), 0, 0);
    check("mid_level4", 64'(level), 64'd4);
    reset_dut();
    #1;
    check("mid_rst_level", 64'(level), 64'd0);
    cycle(1, RND_W'(32'hABC), 0, 0);
    check("mid_first_valid", 64'(if0.out_valid), 64'd1);
    check("mid_first_word",  64'(if0.out_bus),   64'(32'hABC));
    cycle(0, '0, 1, 0);

    // Randomized traffic with biased phases and occasional flush
    for (int i = 0; i < 800; i++) begin
      r64    = {$urandom, $urandom};
      iv_r   = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ordy_r = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      fl_r   = ($urandom_range(0, 39) == 0);
      cycle(iv_r, r64[RND_W-1:0], ordy_r, fl_r);
    end
    cycle(0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
